// File: rtl/decimator_avg_if.sv
// Sample-path bus for the decimator: strobe/config/data in, decimated data out.
// The master drives samples and configuration, and the slave returns decimated data.
interface decimator_avg_if #(
  parameter int WIDTH    = 8,
  parameter int MAX_LOG2 = 4
);
  localparam int KW = $clog2(MAX_LOG2 + 1);

  logic             ce;
  logic             clear;
  logic             mode;
  logic [KW-1:0]    ratio_log2;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             out_valid;
  logic             busy;

  modport master (
    output ce, clear, mode, ratio_log2, data_in,
    input  data_out, out_valid, busy
  );

  modport slave (
    input  ce, clear, mode, ratio_log2, data_in,
    output data_out, out_valid, busy
  );
endinterface

// File: rtl/decimator_avg.sv
// Runtime-configurable 2^k decimator with pick-last or rounded boxcar-average output.
// Ratio and mode only change at frame boundaries so a frame is never mixed.
module decimator_avg #(
  parameter int WIDTH    = 8,
  parameter int MAX_LOG2 = 4,
  parameter int SIGNED   = 0,
  parameter int ROUND    = 1
) (
  input logic           clk,
  input logic           reset,
  decimator_avg_if.slave bus
);
  localparam int KW = $clog2(MAX_LOG2 + 1);
  localparam int CW = MAX_LOG2 + 1;
  localparam int AW = WIDTH + MAX_LOG2;

  logic [CW-1:0]    count_q, count_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] dataOut_q, dataOut_d;
  logic             outValid_q, outValid_d;
  logic [KW-1:0]    kAct_q, kAct_d;
  logic             modeAct_q, modeAct_d;

  logic [KW-1:0]        kReq;
  logic [CW-1:0]        lastCount;
  logic                 signFill;
  logic [AW-1:0]        sampleExt;
  logic [AW-1:0]        sum;
  logic [AW-1:0]        roundAdd;
  logic [AW-1:0]        roundedSum;
  logic signed [AW-1:0] roundedSigned;
  logic [WIDTH-1:0]     avgOut;
  logic                 frameDone;
  logic                 latchCfg;

  assign kReq      = (bus.ratio_log2 > KW'(MAX_LOG2)) ? KW'(MAX_LOG2) : bus.ratio_log2;
  assign lastCount = (CW'(1) << kAct_q) - CW'(1);
  assign signFill  = (SIGNED != 0) ? bus.data_in[WIDTH-1] : 1'b0;
  assign sampleExt = {{MAX_LOG2{signFill}}, bus.data_in};

  // A frame start ignores whatever the accumulator held from the previous frame.
  assign sum           = ((count_q == '0) ? '0 : acc_q) + sampleExt;
  assign roundAdd      = (ROUND != 0 && kAct_q != '0) ? (AW'(1) << (kAct_q - KW'(1))) : '0;
  assign roundedSum    = sum + roundAdd;
  assign roundedSigned = roundedSum;

  always_comb begin
    avgOut = '0;
    if (SIGNED != 0) begin
      avgOut = WIDTH'(roundedSigned >>> kAct_q);
    end else begin
      avgOut = WIDTH'(roundedSum >> kAct_q);
    end
  end

  assign frameDone = bus.ce && !bus.clear && (count_q == lastCount);
  assign latchCfg  = bus.clear || frameDone || (count_q == '0 && !bus.ce);

  always_comb begin
    count_d    = count_q;
    acc_d      = acc_q;
    dataOut_d  = dataOut_q;
    outValid_d = 1'b0;
    kAct_d     = kAct_q;
    modeAct_d  = modeAct_q;
    if (latchCfg) begin
      kAct_d    = kReq;
      modeAct_d = bus.mode;
    end
    if (bus.clear) begin
      count_d = '0;
      acc_d   = '0;
    end else if (bus.ce) begin
      acc_d = sum;
      if (frameDone) begin
        count_d    = '0;
        outValid_d = 1'b1;
        dataOut_d  = modeAct_q ? avgOut : bus.data_in;
      end else begin
        count_d = count_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q    <= '0;
      acc_q      <= '0;
      dataOut_q  <= '0;
      outValid_q <= 1'b0;
      kAct_q     <= '0;
      modeAct_q  <= 1'b0;
    end else begin
      count_q    <= count_d;
      acc_q      <= acc_d;
      dataOut_q  <= dataOut_d;
      outValid_q <= outValid_d;
      kAct_q     <= kAct_d;
      modeAct_q  <= modeAct_d;
    end
  end

  assign bus.data_out  = dataOut_q;
  assign bus.out_valid = outValid_q;
  assign bus.busy      = (count_q != '0);
endmodule

// File: tb/tb_decimator_avg.sv
// Directed bench for decimator_avg: three instances (unsigned round, unsigned truncate,
// signed round) share one stimulus stream; a vector table plus hand-written corner sequences.
module tb_decimator_avg;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ce = 1'b0;
  logic       clear = 1'b0;
  logic       mode = 1'b0;
  logic [2:0] ratio = 3'd0;
  logic [7:0] din = 8'd0;

  int errors = 0;
  int checks = 0;
  int pulses = 0;

  always #5 clk = ~clk;

  decimator_avg_if #(.WIDTH(8), .MAX_LOG2(4)) ifA ();
  decimator_avg_if #(.WIDTH(8), .MAX_LOG2(4)) ifB ();
  decimator_avg_if #(.WIDTH(8), .MAX_LOG2(4)) ifS ();

  assign ifA.ce = ce;  assign ifA.clear = clear;  assign ifA.mode = mode;
  assign ifA.ratio_log2 = ratio;  assign ifA.data_in = din;
  assign ifB.ce = ce;  assign ifB.clear = clear;  assign ifB.mode = mode;
  assign ifB.ratio_log2 = ratio;  assign ifB.data_in = din;
  assign ifS.ce = ce;  assign ifS.clear = clear;  assign ifS.mode = mode;
  assign ifS.ratio_log2 = ratio;  assign ifS.data_in = din;

  decimator_avg #(.WIDTH(8), .MAX_LOG2(4), .SIGNED(0), .ROUND(1)) dutA (
    .clk(clk), .reset(reset), .bus(ifA.slave));
  decimator_avg #(.WIDTH(8), .MAX_LOG2(4), .SIGNED(0), .ROUND(0)) dutB (
    .clk(clk), .reset(reset), .bus(ifB.slave));
  decimator_avg #(.WIDTH(8), .MAX_LOG2(4), .SIGNED(1), .ROUND(1)) dutS (
    .clk(clk), .reset(reset), .bus(ifS.slave));

  typedef struct {
    logic       ce;
    logic       mode;
    logic [2:0] ratio;
    logic [7:0] din;
    logic       expValid;
    logic [7:0] expA;
    logic [7:0] expB;
    logic       expBusy;
  } vec_t;

  vec_t vecs[$];

  function automatic void addVec(input logic c, input logic m, input logic [2:0] r,
                                 input logic [7:0] d, input logic v, input logic [7:0] ea,
                                 input logic [7:0] eb, input logic bz);
    vec_t t;
    t.ce = c; t.mode = m; t.ratio = r; t.din = d;
    t.expValid = v; t.expA = ea; t.expB = eb; t.expBusy = bz;
    vecs.push_back(t);
  endfunction

  task automatic applyStimulus(input logic c, input logic cl, input logic m,
                               input logic [2:0] r, input logic [7:0] d);
    @(negedge clk);
    ce = c; clear = cl; mode = m; ratio = r; din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    #1 reset = 1'b1;
    #2;
    checkOutput("resetOutA", ifA.data_out, 8'd0);
    checkOutput("resetValidA", ifA.out_valid, 1'b0);
    checkOutput("resetBusyA", ifA.busy, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // Vector table: pick k=2, average k=2, mid-frame reconfigure, clamp to 16, full scale
    addVec(0, 0, 3'd2, 8'd0, 0, 8'd0, 8'd0, 0);
    for (int i = 1; i <= 12; i++)
      addVec(1, 0, 3'd2, 8'(i), (i % 4) == 0, 8'((i / 4) * 4), 8'((i / 4) * 4), (i % 4) != 0);
    addVec(0, 1, 3'd2, 8'd0, 0, 8'd12, 8'd12, 0);
    addVec(1, 1, 3'd2, 8'd1, 0, 8'd12, 8'd12, 1);
    addVec(1, 1, 3'd2, 8'd2, 0, 8'd12, 8'd12, 1);
    addVec(1, 1, 3'd2, 8'd3, 0, 8'd12, 8'd12, 1);
    addVec(1, 1, 3'd2, 8'd4, 1, 8'd3, 8'd2, 0);
    addVec(1, 1, 3'd2, 8'd10, 0, 8'd3, 8'd2, 1);
    addVec(1, 1, 3'd2, 8'd10, 0, 8'd3, 8'd2, 1);
    addVec(1, 1, 3'd2, 8'd10, 0, 8'd3, 8'd2, 1);
    addVec(1, 1, 3'd2, 8'd11, 1, 8'd10, 8'd10, 0);
    addVec(0, 0, 3'd2, 8'd0, 0, 8'd10, 8'd10, 0);
    addVec(1, 0, 3'd2, 8'd5, 0, 8'd10, 8'd10, 1);
    addVec(1, 0, 3'd2, 8'd6, 0, 8'd10, 8'd10, 1);
    addVec(1, 1, 3'd0, 8'd7, 0, 8'd10, 8'd10, 1);
    addVec(1, 1, 3'd0, 8'd8, 1, 8'd8, 8'd8, 0);
    addVec(1, 1, 3'd0, 8'd9, 1, 8'd9, 8'd9, 0);
    addVec(1, 1, 3'd0, 8'd200, 1, 8'd200, 8'd200, 0);
    addVec(0, 1, 3'd7, 8'd0, 0, 8'd200, 8'd200, 0);
    for (int i = 1; i <= 16; i++)
      addVec(1, 1, 3'd7, 8'(i), i == 16, (i == 16) ? 8'd9 : 8'd200,
             (i == 16) ? 8'd8 : 8'd200, i != 16);
    addVec(0, 1, 3'd2, 8'd0, 0, 8'd9, 8'd8, 0);
    addVec(1, 1, 3'd2, 8'd255, 0, 8'd9, 8'd8, 1);
    addVec(1, 1, 3'd2, 8'd255, 0, 8'd9, 8'd8, 1);
    addVec(1, 1, 3'd2, 8'd255, 0, 8'd9, 8'd8, 1);
    addVec(1, 1, 3'd2, 8'd254, 1, 8'd255, 8'd254, 0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].ce, 1'b0, vecs[i].mode, vecs[i].ratio, vecs[i].din);
      checkOutput($sformatf("vec%0d.valid", i), ifA.out_valid, vecs[i].expValid);
      checkOutput($sformatf("vec%0d.outA", i), ifA.data_out, vecs[i].expA);
      checkOutput($sformatf("vec%0d.outB", i), ifB.data_out, vecs[i].expB);
      checkOutput($sformatf("vec%0d.busy", i), ifA.busy, vecs[i].expBusy);
    end

    // Clear coincident with the frame-completing sample discards it
    applyStimulus(1, 0, 1, 3'd2, 8'd1);
    applyStimulus(1, 0, 1, 3'd2, 8'd2);
    applyStimulus(1, 0, 1, 3'd2, 8'd3);
    checkOutput("clearPreBusy", ifA.busy, 1'b1);
    applyStimulus(1, 1, 1, 3'd2, 8'd4);
    checkOutput("clearValid", ifA.out_valid, 1'b0);
    checkOutput("clearBusy", ifA.busy, 1'b0);
    checkOutput("clearHoldA", ifA.data_out, 8'd255);
    checkOutput("clearHoldB", ifB.data_out, 8'd254);
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 1, 3'd2, 8'd4);
    checkOutput("afterClearValid", ifA.out_valid, 1'b1);
    checkOutput("afterClearOutA", ifA.data_out, 8'd4);

    // Sparse strobe: one accepted sample every third cycle
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, 1, 3'd2, (i < 2) ? 8'd8 : 8'd9);
      if (ifA.out_valid) pulses++;
      for (int j = 0; j < 2; j++) begin
        applyStimulus(0, 0, 1, 3'd2, 8'd0);
        if (ifA.out_valid) pulses++;
      end
    end
    checkOutput("sparsePulses", 8'(pulses), 8'd1);
    checkOutput("sparseOutA", ifA.data_out, 8'd9);
    checkOutput("sparseOutB", ifB.data_out, 8'd8);

    // Asynchronous reset between edges in the middle of a frame
    applyStimulus(1, 0, 1, 3'd2, 8'd50);
    applyStimulus(1, 0, 1, 3'd2, 8'd60);
    checkOutput("midFrameBusy", ifA.busy, 1'b1);
    #2 reset = 1'b1;
    #1;
    checkOutput("asyncOutA", ifA.data_out, 8'd0);
    checkOutput("asyncValidA", ifA.out_valid, 1'b0);
    checkOutput("asyncBusyA", ifA.busy, 1'b0);
    checkOutput("asyncOutS", ifS.data_out, 8'd0);
    @(negedge clk);
    reset = 1'b0; ce = 1'b1; clear = 1'b0; mode = 1'b0; ratio = 3'd1; din = 8'd77;
    @(posedge clk);
    #1;
    checkOutput("postResetValid", ifA.out_valid, 1'b1);
    checkOutput("postResetOut", ifA.data_out, 8'd77);
    checkOutput("postResetBusy", ifA.busy, 1'b0);

    // Signed average with k=1
    applyStimulus(0, 0, 1, 3'd1, 8'd0);
    applyStimulus(1, 0, 1, 3'd1, 8'hFD);
    checkOutput("signedMidBusy", ifS.busy, 1'b1);
    applyStimulus(1, 0, 1, 3'd1, 8'hFC);
    checkOutput("signedValid1", ifS.out_valid, 1'b1);
    checkOutput("signedOut1", ifS.data_out, 8'hFD);
    applyStimulus(1, 0, 1, 3'd1, 8'h80);
    applyStimulus(1, 0, 1, 3'd1, 8'h80);
    checkOutput("signedOut2", ifS.data_out, 8'h80);
    applyStimulus(1, 0, 1, 3'd1, 8'h7F);
    applyStimulus(1, 0, 1, 3'd1, 8'h81);
    checkOutput("signedOut3", ifS.data_out, 8'h00);
    checkOutput("unsignedOut3", ifA.data_out, 8'h80);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
